// File: rtl/lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lane_scheduler
// Purpose  : Round-robin arbiter merging four buffered byte lanes onto one
//            tagged output stream, preceded by an idle sync preamble.
// Revision : 1.0 - initial release
// ============================================================================
module lane_scheduler #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_CHAR  = 8'hBC,
  parameter int                    SYNC_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada0,
  input  logic [DATA_WIDTH-1:0] Entrada1,
  input  logic [DATA_WIDTH-1:0] Entrada2,
  input  logic [DATA_WIDTH-1:0] Entrada3,
  input  logic                  validEntrada0,
  input  logic                  validEntrada1,
  input  logic                  validEntrada2,
  input  logic                  validEntrada3,
  output logic                  ready0,
  output logic                  ready1,
  output logic                  ready2,
  output logic                  ready3,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic [1:0]            lane_id,
  output logic                  active
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic [DATA_WIDTH-1:0] in_data [4];
  logic [3:0]            in_valid;
  logic [3:0]            ready;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [3:0]            full_q, full_d;
  logic [DATA_WIDTH-1:0] buf_q [4];
  logic [DATA_WIDTH-1:0] buf_d [4];
  logic [DATA_WIDTH-1:0] salida_q, salida_d;
  logic                  valid_q, valid_d;
  logic [1:0]            lane_q, lane_d;
  logic                  active_q, active_d;

  logic                  win_found;
  logic [1:0]            win_lane;

  assign in_data[0] = Entrada0;
  assign in_data[1] = Entrada1;
  assign in_data[2] = Entrada2;
  assign in_data[3] = Entrada3;
  assign in_valid   = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane_ready
      assign ready[g] = !full_q[g] && !reset;
    end
  endgenerate

  assign ready0 = ready[0];
  assign ready1 = ready[1];
  assign ready2 = ready[2];
  assign ready3 = ready[3];

  // First full lane at or after the pointer, in circular order.
  always_comb begin
    win_found = 1'b0;
    win_lane  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && full_q[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_lane  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    full_d   = full_q;
    buf_d    = buf_q;
    salida_d = IDLE_CHAR;
    valid_d  = 1'b0;
    lane_d   = 2'd0;

    // Capture never collides with a grant: a full lane is not ready.
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i] && ready[i]) begin
        full_d[i] = 1'b1;
        buf_d[i]  = in_data[i];
      end
    end

    case (state_q)
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) state_d = ST_RUN;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_HOLD;
        end else if (win_found) begin
          salida_d         = buf_q[win_lane];
          valid_d          = 1'b1;
          lane_d           = win_lane;
          full_d[win_lane] = 1'b0;
          ptr_d            = win_lane + 2'd1;
        end
      end
      ST_HOLD: begin
        if (enable) state_d = ST_RUN;
      end
      default: state_d = ST_SYNC;
    endcase

    active_d = (state_d != ST_SYNC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SYNC;
      cnt_q    <= 4'd0;
      ptr_q    <= 2'd0;
      full_q   <= 4'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      salida_q <= IDLE_CHAR;
      valid_q  <= 1'b0;
      lane_q   <= 2'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      full_q   <= full_d;
      buf_q    <= buf_d;
      salida_q <= salida_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      active_q <= active_d;
    end
  end

  assign Salida      = salida_q;
  assign validSalida = valid_q;
  assign lane_id     = lane_q;
  assign active      = active_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_scheduler.sv
`default_nettype none
// Bench for lane_scheduler: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural lane/queue model.
module tb_lane_scheduler;

  localparam int         SYNC_COUNT = 4;
  localparam logic [7:0] IDLE       = 8'hBC;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic       ready0, ready1, ready2, ready3;
  logic [7:0] Salida;
  logic       validSalida;
  logic [1:0] lane_id;
  logic       active;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_full [4];
  logic [7:0] m_buf  [4];
  int         m_ptr;
  int         m_phase;   // 0 = preamble, 1 = arbitrating, 2 = paused
  int         m_cnt;
  logic [7:0] x_salida;
  logic       x_valid;
  logic [1:0] x_lane;
  logic       x_active;

  always #5 clk = ~clk;

  lane_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .Entrada0     (din[0]),
    .Entrada1     (din[1]),
    .Entrada2     (din[2]),
    .Entrada3     (din[3]),
    .validEntrada0(vin[0]),
    .validEntrada1(vin[1]),
    .validEntrada2(vin[2]),
    .validEntrada3(vin[3]),
    .ready0       (ready0),
    .ready1       (ready1),
    .ready2       (ready2),
    .ready3       (ready3),
    .enable       (enable),
    .Salida       (Salida),
    .validSalida  (validSalida),
    .lane_id      (lane_id),
    .active       (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit cap [4];
    int win;
    int l;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
      m_ptr = 0; m_phase = 0; m_cnt = 0;
      x_salida = IDLE; x_valid = 1'b0; x_lane = 2'd0; x_active = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) cap[i] = vin[i] && !m_full[i];
    win = -1;
    x_salida = IDLE; x_valid = 1'b0; x_lane = 2'd0;
    case (m_phase)
      0: if (m_cnt == SYNC_COUNT - 1) m_phase = 1; else m_cnt++;
      1: begin
        if (!enable) m_phase = 2;
        else begin
          for (int k = 0; k < 4; k++) begin
            l = (m_ptr + k) % 4;
            if (win < 0 && m_full[l]) win = l;
          end
        end
      end
      default: if (enable) m_phase = 1;
    endcase
    if (win >= 0) begin
      x_salida = m_buf[win];
      x_valid  = 1'b1;
      x_lane   = 2'(win);
      m_full[win] = 1'b0;
      m_ptr = (win + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      if (cap[i]) begin
        m_full[i] = 1'b1;
        m_buf[i]  = din[i];
      end
    end
    x_active = (m_phase != 0);
  endfunction

  task automatic cycle();
    logic [3:0] exp_rdy;
    #1;
    for (int i = 0; i < 4; i++) exp_rdy[i] = !m_full[i] && !reset;
    chk("ready", {ready3, ready2, ready1, ready0}, exp_rdy);
    model_step();
    @(posedge clk);
    #1;
    chk("Salida", Salida, x_salida);
    chk("validSalida", validSalida, x_valid);
    chk("lane_id", lane_id, x_lane);
    chk("active", active, x_active);
  endtask

  task automatic drive(input bit r, input bit en, input logic [3:0] v,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    reset  = r;
    enable = en;
    vin    = v;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_buf[i]  = 8'h00;
    end
    m_ptr = 0; m_phase = 0; m_cnt = 0;

    // Reset for two cycles, then the idle preamble
    drive(1'b1, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(6);

    // Single byte on lane 2
    drive(1'b0, 1'b1, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    idle(3);

    // All lanes filled during the preamble with the pointer at lane 0
    drive(1'b1, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
    idle(8);

    // Lanes 0 and 3 streaming continuously
    for (int n = 0; n < 16; n++)
      drive(1'b0, 1'b1, 4'b1001, 8'(n), 8'h00, 8'h00, 8'(8'h80 + n));
    idle(3);

    // Lanes 1 and 2 held while enable is low, then released
    drive(1'b0, 1'b0, 4'b0110, 8'h00, 8'h21, 8'h22, 8'h00);
    drive(1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(4);

    // Reset pulse with every lane full
    drive(1'b0, 1'b0, 4'b1111, 8'h31, 8'h32, 8'h33, 8'h34);
    drive(1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(8);

    // Random traffic with occasional pauses and resets
    repeat (400)
      drive(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 9) != 0),
            4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
